// File: rtl/eth_rx_frame_buffer_if.sv
// Consumer-side byte stream of the receive frame buffer.
// The buffer drives the master side; the consumer uses slave.
interface eth_rx_frame_buffer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/eth_rx_frame_buffer.sv
// Speculative receive frame buffer: bytes are held until the CRC
// verdict, then committed (queued for the consumer) or rolled back.
module eth_rx_frame_buffer #(
    parameter int DEPTH   = 2048,
    parameter int FRAMES  = 8,
    parameter int MAX_LEN = 1518
) (
    input  logic                  eth_clk,
    input  logic                  rst_in,
    input  logic                  frame_start,
    input  logic [7:0]            data_in,
    input  logic                  data_valid,
    input  logic                  frame_commit,
    input  logic                  frame_drop,
    eth_rx_frame_buffer_if.master out_if,
    output logic [15:0]           frames_ok,
    output logic [15:0]           frames_dropped
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int FW  = $clog2(FRAMES);
    localparam int FPW = FW + 1;
    localparam int LW  = $clog2(MAX_LEN + 1);

    localparam logic [PW-1:0]  P_DEPTH  = PW'(DEPTH);
    localparam logic [FPW-1:0] P_FRAMES = FPW'(FRAMES);
    localparam logic [LW-1:0]  L_MAX    = LW'(MAX_LEN);
    localparam logic [LW-1:0]  L_ONE    = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_OVF
    } wstate_t;

    wstate_t         r_state, w_state_nx;
    logic [PW-1:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [PW-1:0]   w_wr_nx, w_cm_nx;
    logic [LW-1:0]   r_len, w_len_nx, w_push_len;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic            w_push, w_ok_inc, w_drop_inc;
    logic            w_full, w_lf_full, w_lf_empty;

    logic [7:0]      r_mem [DEPTH];
    logic [LW-1:0]   r_lf_mem [FRAMES];
    logic [FPW-1:0]  r_lf_wp, r_lf_rp, r_lf_fp;

    logic [AW-1:0]   r_fetch_ptr;
    logic [LW-1:0]   r_f_remain, w_head_len;
    logic            w_load_out, w_q_free, w_pop, w_fetch;
    logic            w_fetch_last, w_xfer;
    logic            r_q_valid, r_q_last;
    logic [7:0]      r_q_data;
    logic            r_out_valid, r_out_last;
    logic [7:0]      r_out_data;
    logic [15:0]     r_frames_ok, r_frames_dropped;

    assign w_full     = (r_wr_ptr - r_rd_ptr) == P_DEPTH;
    // A frame holds its length entry until its last byte is consumed.
    assign w_lf_full  = (r_lf_wp - r_lf_fp) == P_FRAMES;
    assign w_lf_empty = r_lf_wp == r_lf_rp;
    assign w_head_len = r_lf_mem[r_lf_rp[FW-1:0]];

    // Write side: old-frame byte, then verdict, then a new frame opens.
    always_comb begin
        w_state_nx = r_state;
        w_wr_nx    = r_wr_ptr;
        w_cm_nx    = r_commit_ptr;
        w_len_nx   = r_len;
        w_we       = 1'b0;
        w_waddr    = r_wr_ptr[AW-1:0];
        w_push     = 1'b0;
        w_push_len = r_len;
        w_ok_inc   = 1'b0;
        w_drop_inc = 1'b0;
        if (!frame_start && data_valid && r_state == S_FILL) begin
            if (!w_full && r_len < L_MAX) begin
                w_we     = 1'b1;
                w_wr_nx  = r_wr_ptr + PW'(1);
                w_len_nx = r_len + L_ONE;
            end else begin
                w_state_nx = S_OVF;
            end
        end
        if (frame_commit || frame_drop) begin
            if (w_state_nx == S_FILL && frame_commit && !frame_drop
                && w_len_nx != '0 && !w_lf_full) begin
                w_push     = 1'b1;
                w_push_len = w_len_nx;
                w_cm_nx    = w_wr_nx;
                w_ok_inc   = 1'b1;
                w_state_nx = S_IDLE;
            end else if (w_state_nx != S_IDLE) begin
                w_wr_nx    = r_commit_ptr;
                w_drop_inc = 1'b1;
                w_state_nx = S_IDLE;
            end
        end
        if (frame_start) begin
            w_wr_nx    = w_cm_nx;
            w_len_nx   = '0;
            w_state_nx = S_FILL;
            if (data_valid) begin
                if ((w_cm_nx - r_rd_ptr) != P_DEPTH) begin
                    w_we     = 1'b1;
                    w_waddr  = w_cm_nx[AW-1:0];
                    w_wr_nx  = w_cm_nx + PW'(1);
                    w_len_nx = L_ONE;
                end else begin
                    w_state_nx = S_OVF;
                end
            end
        end
    end

    // Write-side state, pointers and length FIFO write pointer.
    always_ff @(posedge eth_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_len        <= '0;
            r_lf_wp      <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_wr_ptr     <= w_wr_nx;
            r_commit_ptr <= w_cm_nx;
            r_len        <= w_len_nx;
            r_lf_wp      <= r_lf_wp + FPW'(w_push);
        end
    end

    // Saturating frame counters.
    always_ff @(posedge eth_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_frames_ok      <= '0;
            r_frames_dropped <= '0;
        end else begin
            if (w_ok_inc && r_frames_ok != 16'hFFFF)
                r_frames_ok <= r_frames_ok + 16'd1;
            if (w_drop_inc && r_frames_dropped != 16'hFFFF)
                r_frames_dropped <= r_frames_dropped + 16'd1;
        end
    end

    // Storage: byte RAM with synchronous read, plus length entries.
    always_ff @(posedge eth_clk) begin
        if (w_we)
            r_mem[w_waddr] <= data_in;
        if (w_fetch)
            r_q_data <= r_mem[r_fetch_ptr];
        if (w_push)
            r_lf_mem[r_lf_wp[FW-1:0]] <= w_push_len;
    end

    assign w_load_out   = !r_out_valid || out_if.out_ready;
    assign w_q_free     = !r_q_valid || w_load_out;
    assign w_pop        = r_f_remain == '0 && !w_lf_empty && w_q_free;
    assign w_fetch      = w_q_free && (w_pop || r_f_remain != '0);
    assign w_fetch_last = w_pop ? (w_head_len == L_ONE)
                                : (r_f_remain == L_ONE);
    assign w_xfer       = r_out_valid && out_if.out_ready;

    // Read side: pop length, fetch bytes, register the presented byte.
    always_ff @(posedge eth_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_ptr    <= '0;
            r_fetch_ptr <= '0;
            r_f_remain  <= '0;
            r_lf_rp     <= '0;
            r_lf_fp     <= '0;
            r_q_valid   <= 1'b0;
            r_q_last    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_lf_rp <= r_lf_rp + FPW'(w_pop);
            if (w_pop)
                r_f_remain <= w_head_len - L_ONE;
            else if (w_fetch)
                r_f_remain <= r_f_remain - L_ONE;
            r_fetch_ptr <= r_fetch_ptr + AW'(w_fetch);
            if (w_q_free) begin
                r_q_valid <= w_fetch;
                r_q_last  <= w_fetch_last;
            end
            if (w_load_out) begin
                r_out_valid <= r_q_valid;
                r_out_last  <= r_q_valid && r_q_last;
                if (r_q_valid)
                    r_out_data <= r_q_data;
            end
            r_rd_ptr <= r_rd_ptr + PW'(w_xfer);
            r_lf_fp  <= r_lf_fp + FPW'(w_xfer && r_out_last);
        end
    end

    assign out_if.out_data  = r_out_data;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_last  = r_out_last;
    assign frames_ok        = r_frames_ok;
    assign frames_dropped   = r_frames_dropped;
endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Directed bench: index 0 is a DEPTH=2048 buffer, index 1 a
// DEPTH=64 buffer; each scenario task checks its own results.
module tb_eth_rx_frame_buffer;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst [2];
    logic       fs [2], dv [2], fc [2], fd [2], rdy [2];
    logic [7:0] di [2];
    logic [7:0] od [2];
    logic       ov [2], ol [2];
    logic [15:0] fok [2], fdr [2];
    wire  [15:0] fok0, fok1, fdr0, fdr1;
    int total = 0;
    int bad = 0;

    eth_rx_frame_buffer_if if0 ();
    eth_rx_frame_buffer_if if1 ();

    eth_rx_frame_buffer #(.DEPTH(2048), .FRAMES(8), .MAX_LEN(1518)) u_big (
        .eth_clk(clk), .rst_in(rst[0]), .frame_start(fs[0]),
        .data_in(di[0]), .data_valid(dv[0]), .frame_commit(fc[0]),
        .frame_drop(fd[0]), .out_if(if0), .frames_ok(fok0),
        .frames_dropped(fdr0));

    eth_rx_frame_buffer #(.DEPTH(64), .FRAMES(8), .MAX_LEN(1518)) u_small (
        .eth_clk(clk), .rst_in(rst[1]), .frame_start(fs[1]),
        .data_in(di[1]), .data_valid(dv[1]), .frame_commit(fc[1]),
        .frame_drop(fd[1]), .out_if(if1), .frames_ok(fok1),
        .frames_dropped(fdr1));

    assign fok[0] = fok0;
    assign fok[1] = fok1;
    assign fdr[0] = fdr0;
    assign fdr[1] = fdr1;
    assign od[0] = if0.out_data;
    assign od[1] = if1.out_data;
    assign ov[0] = if0.out_valid;
    assign ov[1] = if1.out_valid;
    assign ol[0] = if0.out_last;
    assign ol[1] = if1.out_last;
    assign if0.out_ready = rdy[0];
    assign if1.out_ready = rdy[1];

    // Drives n bytes base, base+1, ...; start rides on the first byte and
    // the verdict (commit or drop) rides on the last byte. Call at negedge.
    task automatic send(input int d, input int n, input logic [7:0] base,
                        input bit commit);
        for (int i = 0; i < n; i++) begin
            fs[d] = (i == 0);
            dv[d] = 1'b1;
            di[d] = base + 8'(i);
            fc[d] = commit && (i == n - 1);
            fd[d] = !commit && (i == n - 1);
            @(negedge clk);
        end
        fs[d] = 1'b0;
        dv[d] = 1'b0;
        fc[d] = 1'b0;
        fd[d] = 1'b0;
    endtask

    // Consumes one frame, tallying data, last-flag and stall-hold errors.
    task automatic collect(input int d, input int n, input logic [7:0] base,
                           input bit rnd, output int got, output int derr,
                           output int lerr, output int serr);
        bit         stl;
        logic [7:0] pd, e;
        logic       pl;
        got = 0; derr = 0; lerr = 0; serr = 0;
        stl = 1'b0; pd = '0; pl = 1'b0;
        for (int c = 0; c < n * 4 + 60 && got < n; c++) begin
            if (stl && (ov[d] !== 1'b1 || od[d] !== pd || ol[d] !== pl))
                serr++;
            rdy[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ov[d] === 1'b1 && rdy[d]) begin
                e = base + 8'(got);
                if (od[d] !== e) derr++;
                if (ol[d] !== (got == n - 1)) lerr++;
                got++;
            end
            stl = ov[d] && !rdy[d];
            pd = od[d];
            pl = ol[d];
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (ov[0] !== 1'b0) begin bad++;
            $display("FAIL rst_valid got=%0b want=0", ov[0]); end
        total++; if (od[0] !== 8'h00) begin bad++;
            $display("FAIL rst_data got=%h want=00", od[0]); end
        total++; if (ol[0] !== 1'b0) begin bad++;
            $display("FAIL rst_last got=%0b want=0", ol[0]); end
        total++; if (fok[0] !== 16'd0 || fdr[0] !== 16'd0) begin bad++;
            $display("FAIL rst_cnt got=%0d/%0d want=0/0", fok[0], fdr[0]); end
        total++; if (ov[1] !== 1'b0) begin bad++;
            $display("FAIL rst_valid_small got=%0b want=0", ov[1]); end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int g, de, le, se;
        rdy[0] = 1'b1;
        send(0, 60, 8'h00, 1'b1);
        total++; if (ov[0] !== 1'b0) begin bad++;
            $display("FAIL lat_c1 got=%0b want=0", ov[0]); end
        @(negedge clk);
        total++; if (ov[0] !== 1'b0) begin bad++;
            $display("FAIL lat_c2 got=%0b want=0", ov[0]); end
        @(negedge clk);
        total++; if (ov[0] !== 1'b1) begin bad++;
            $display("FAIL lat_c3 got=%0b want=1", ov[0]); end
        collect(0, 60, 8'h00, 1'b0, g, de, le, se);
        total++; if (g !== 60 || de !== 0 || le !== 0) begin bad++;
            $display("FAIL basic_frame got=%0d de=%0d le=%0d want=60/0/0",
                     g, de, le); end
        repeat (5) @(negedge clk);
        total++; if (ov[0] !== 1'b0) begin bad++;
            $display("FAIL basic_extra got=%0b want=0", ov[0]); end
        total++; if (fok[0] !== 16'd1) begin bad++;
            $display("FAIL basic_ok got=%0d want=1", fok[0]); end
    endtask

    task automatic test_drop();
        int g, de, le, se;
        bit seen;
        rdy[0] = 1'b1;
        send(0, 64, 8'h40, 1'b0);
        seen = 1'b0;
        repeat (10) begin
            if (ov[0] === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++;
            $display("FAIL drop_visible got=%0b want=0", seen); end
        total++; if (fdr[0] !== 16'd1) begin bad++;
            $display("FAIL drop_cnt got=%0d want=1", fdr[0]); end
        send(0, 46, 8'h80, 1'b1);
        collect(0, 46, 8'h80, 1'b0, g, de, le, se);
        total++; if (g !== 46 || de !== 0 || le !== 0) begin bad++;
            $display("FAIL drop_next got=%0d de=%0d le=%0d want=46/0/0",
                     g, de, le); end
        total++; if (fok[0] !== 16'd2) begin bad++;
            $display("FAIL drop_ok got=%0d want=2", fok[0]); end
    endtask

    task automatic test_ovf();
        int g, de, le, se;
        rdy[1] = 1'b0;
        send(1, 40, 8'h10, 1'b1);
        repeat (4) @(negedge clk);
        send(1, 30, 8'hA0, 1'b1);
        repeat (2) @(negedge clk);
        total++; if (fok[1] !== 16'd1 || fdr[1] !== 16'd1) begin bad++;
            $display("FAIL ovf_cnt got=%0d/%0d want=1/1", fok[1], fdr[1]); end
        total++; if (ov[1] !== 1'b1 || od[1] !== 8'h10) begin bad++;
            $display("FAIL ovf_hold got=%0b/%h want=1/10", ov[1], od[1]); end
        collect(1, 40, 8'h10, 1'b0, g, de, le, se);
        total++; if (g !== 40 || de !== 0 || le !== 0) begin bad++;
            $display("FAIL ovf_first got=%0d de=%0d le=%0d want=40/0/0",
                     g, de, le); end
        repeat (3) @(negedge clk);
        total++; if (ov[1] !== 1'b0) begin bad++;
            $display("FAIL ovf_extra got=%0b want=0", ov[1]); end
    endtask

    task automatic test_maxlen();
        int g, de, le, se;
        rdy[0] = 1'b1;
        send(0, 1519, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (fdr[0] !== 16'd2 || ov[0] !== 1'b0) begin bad++;
            $display("FAIL max_1519 got=%0d/%0b want=2/0", fdr[0], ov[0]); end
        send(0, 1518, 8'h00, 1'b1);
        collect(0, 1518, 8'h00, 1'b0, g, de, le, se);
        total++; if (g !== 1518 || de !== 0 || le !== 0) begin bad++;
            $display("FAIL max_1518 got=%0d de=%0d le=%0d want=1518/0/0",
                     g, de, le); end
        total++; if (fok[0] !== 16'd3) begin bad++;
            $display("FAIL max_ok got=%0d want=3", fok[0]); end
    endtask

    task automatic test_fifo_full();
        int g, de, le, se;
        bit seen;
        rdy[1] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(1, 7, 8'h30 + 8'(i * 16), 1'b1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        total++; if (fok[1] !== 16'd9 || fdr[1] !== 16'd2) begin bad++;
            $display("FAIL ff_cnt got=%0d/%0d want=9/2", fok[1], fdr[1]); end
        for (int i = 0; i < 8; i++) begin
            collect(1, 7, 8'h30 + 8'(i * 16), 1'b1, g, de, le, se);
            total++;
            if (g !== 7 || de !== 0 || le !== 0 || se !== 0) begin bad++;
                $display("FAIL ff_frame%0d got=%0d de=%0d le=%0d se=%0d want=7/0/0/0",
                         i, g, de, le, se); end
        end
        rdy[1] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            if (ov[1] === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++;
            $display("FAIL ff_ninth got=%0b want=0", seen); end
    endtask

    task automatic test_reset_mid();
        int g, de, le, se;
        rdy[0] = 1'b0;
        send(0, 20, 8'h70, 1'b1);
        repeat (5) @(negedge clk);
        total++; if (ov[0] !== 1'b1 || od[0] !== 8'h70) begin bad++;
            $display("FAIL rm_pre got=%0b/%h want=1/70", ov[0], od[0]); end
        rst[0] = 1'b0;
        #1;
        total++; if (ov[0] !== 1'b0 || od[0] !== 8'h00 || ol[0] !== 1'b0) begin
            bad++;
            $display("FAIL rm_out got=%0b/%h/%0b want=0/00/0",
                     ov[0], od[0], ol[0]); end
        total++; if (fok[0] !== 16'd0 || fdr[0] !== 16'd0) begin bad++;
            $display("FAIL rm_cnt got=%0d/%0d want=0/0", fok[0], fdr[0]); end
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b1;
        send(0, 50, 8'h55, 1'b1);
        collect(0, 50, 8'h55, 1'b0, g, de, le, se);
        total++; if (g !== 50 || de !== 0 || le !== 0) begin bad++;
            $display("FAIL rm_fresh got=%0d de=%0d le=%0d want=50/0/0",
                     g, de, le); end
        total++; if (fok[0] !== 16'd1 || fdr[0] !== 16'd0) begin bad++;
            $display("FAIL rm_cnt2 got=%0d/%0d want=1/0", fok[0], fdr[0]); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            fs[d] = 1'b0;
            dv[d] = 1'b0;
            fc[d] = 1'b0;
            fd[d] = 1'b0;
            di[d] = 8'h00;
            rdy[d] = 1'b0;
        end
        test_reset();
        test_basic();
        test_drop();
        test_ovf();
        test_maxlen();
        test_fifo_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
